// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu: opcode encodings, multiply FSM states and
// the multiply iteration count.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  localparam int MUL_ITERS = 8;

endpackage

// File: rtl/mul8_shift_add.sv
// 8x8 unsigned shift-and-add multiplier, one iteration per clock.
// Exists only when SEQ_ALU_MUL_EN is defined.
// start loads the operands and clears the accumulator and counter.
// run advances one iteration.
// done flags the final iteration. product is the accumulator value after
// the current iteration, so the parent can register the finished product
// on the same edge.
`ifdef SEQ_ALU_MUL_EN
module mul8_shift_add
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        run,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        done,
  output logic [15:0] product
);

  // Bit 0 of the conceptual 16-bit accumulator is always zero until the
  // last shift, so only bits [15:1] are stored.
  logic [14:0] acc;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic [2:0]  cnt;
  logic [8:0]  sum;

  // Add the multiplicand into the upper byte when the multiplier LSB is set.
  always_comb begin
    sum = {1'b0, acc[14:7]} + (mplier[0] ? {1'b0, mcand} : 9'd0);
  end

  assign product = {sum, acc[6:0]};
  assign done    = run && (cnt == 3'(MUL_ITERS - 1));

  // Operand load on start, then shift right through the carry each iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
    end else if (run) begin
      acc    <= {sum, acc[6:1]};
      mplier <= {1'b0, mplier[7:1]};
      cnt    <= cnt + 3'd1;
    end
  end

endmodule
`endif

// File: rtl/seq_alu.sv
// seq_alu: 8-bit ALU for the accumulator/flag write-back stage.
// Logic, add/sub and shift operations complete one cycle after START.
// Macro SEQ_ALU_MUL_EN enables the 8-iteration shift-and-add multiply
// (OP=111). Without the macro, OP=111 completes in one cycle with a zero
// result and BUSY is tied low.
module seq_alu (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [2:0] OP,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] Y,
  output logic [7:0] YH,
  output logic       CF,
  output logic       ZF,
  output logic       BUSY,
  output logic       DONE
);
  import alu_pkg::*;

  logic [7:0] res;
  logic       carry;

  // Single-cycle result and carry.
  // Without the multiplier, OP_MUL falls through to a zero result.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (OP)
      OP_ADD:  {carry, res} = {1'b0, A} + {1'b0, B};
      OP_SUB:  {carry, res} = {1'b0, A} - {1'b0, B};
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_SHL:  {carry, res} = {A, 1'b0};
      OP_SHR:  {res, carry} = {1'b0, A};
      default: res = '0;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  state_t      state;
  logic        mul_start;
  logic        mul_run;
  logic        mul_done;
  logic [15:0] mul_product;

  assign mul_start = (state == S_IDLE) && START && (OP == OP_MUL);
  assign mul_run   = (state == S_MUL);

  mul8_shift_add u_mul (
    .clk     (CLK),
    .rst_n   (RST_N),
    .start   (mul_start),
    .run     (mul_run),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_product)
  );

  // Issue FSM with registered results; a multiply only writes back on its last iteration.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      Y     <= '0;
      YH    <= '0;
      CF    <= 1'b0;
      ZF    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            if (OP == OP_MUL) begin
              state <= S_MUL;
              BUSY  <= 1'b1;
            end else begin
              Y    <= res;
              YH   <= '0;
              CF   <= carry;
              ZF   <= (res == 8'h00);
              DONE <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
            Y     <= mul_product[7:0];
            YH    <= mul_product[15:8];
            CF    <= |mul_product[15:8];
            ZF    <= (mul_product[7:0] == 8'h00);
            DONE  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign BUSY = 1'b0;

  // Every operation, including OP_MUL, writes back one cycle after START.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Y    <= '0;
      YH   <= '0;
      CF   <= 1'b0;
      ZF   <= 1'b0;
      DONE <= 1'b0;
    end else begin
      DONE <= START;
      if (START) begin
        Y  <= res;
        YH <= '0;
        CF <= carry;
        ZF <= (res == 8'h00);
      end
    end
  end
`endif

endmodule
